// File: rtl/dht11_responder.sv
// DHT11 sensor emulator on a single open-drain wire: waits for a host start
// pulse, then answers with acknowledge, 40 data bits and an end-of-frame low.
module dht11_responder #(
    parameter int unsigned T_START_MIN = 900_000,
    parameter int unsigned T_RESP_DLY  = 1_500,
    parameter int unsigned T_ACK       = 4_000,
    parameter int unsigned T_BIT_LOW   = 2_500,
    parameter int unsigned T_ZERO_HI   = 1_350,
    parameter int unsigned T_ONE_HI    = 3_500,
    parameter int unsigned T_HOLDOFF   = 50_000_000
) (
    input  logic       clk,
    input  logic       nRST,
    inout  wire        Data,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK_LO,
        S_ACK_HI,
        S_BIT_LO,
        S_BIT_HI,
        S_EOT,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [5:0]  r_bit_cnt;
    logic [39:0] r_shift;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync_d;
    logic        r_drive_low;
    logic        r_busy;
    logic        r_frame_done;

    logic        w_rise;
    logic [31:0] w_cnt_inc;
    logic [31:0] w_hi_last;
    logic [7:0]  w_checksum;

    // Open drain: the wire is only ever pulled low or released.
    assign Data       = r_drive_low ? 1'b0 : 1'bz;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    assign w_rise     = r_sync2 & ~r_sync_d;
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 32'd1;
    assign w_hi_last  = r_shift[39] ? (T_ONE_HI - 32'd1) : (T_ZERO_HI - 32'd1);
    assign w_checksum = hum_int + hum_dec + temp_int + temp_dec;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= Data;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_drive_low  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_drive_low <= 1'b0;
                    // The low time is judged on the release edge, so a start
                    // held low indefinitely simply saturates and waits here.
                    if (w_rise) begin
                        r_cnt <= '0;
                        if (r_cnt >= T_START_MIN) begin
                            r_state <= S_WAIT;
                            r_busy  <= 1'b1;
                        end
                    end else if (!r_sync2) begin
                        r_cnt <= w_cnt_inc;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == T_RESP_DLY - 32'd1) begin
                        r_cnt       <= '0;
                        r_shift     <= {hum_int, hum_dec, temp_int, temp_dec, w_checksum};
                        r_bit_cnt   <= '0;
                        r_drive_low <= 1'b1;
                        r_state     <= S_ACK_LO;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_ACK_LO: begin
                    if (r_cnt == T_ACK - 32'd1) begin
                        r_cnt       <= '0;
                        r_drive_low <= 1'b0;
                        r_state     <= S_ACK_HI;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_ACK_HI: begin
                    if (r_cnt == T_ACK - 32'd1) begin
                        r_cnt       <= '0;
                        r_drive_low <= 1'b1;
                        r_state     <= S_BIT_LO;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_BIT_LO: begin
                    if (r_cnt == T_BIT_LOW - 32'd1) begin
                        r_cnt       <= '0;
                        r_drive_low <= 1'b0;
                        r_state     <= S_BIT_HI;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_BIT_HI: begin
                    if (r_cnt == w_hi_last) begin
                        r_cnt       <= '0;
                        r_shift     <= {r_shift[38:0], 1'b0};
                        r_bit_cnt   <= r_bit_cnt + 6'd1;
                        r_drive_low <= 1'b1;
                        r_state     <= (r_bit_cnt == 6'd39) ? S_EOT : S_BIT_LO;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_EOT: begin
                    if (r_cnt == T_BIT_LOW - 32'd1) begin
                        r_cnt        <= '0;
                        r_drive_low  <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= S_HOLD;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_HOLD: begin
                    r_drive_low <= 1'b0;
                    if (r_cnt == T_HOLDOFF - 32'd1) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_cnt       <= '0;
                    r_drive_low <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
